note_stabilizer: RTL
====================

// Module: note_stabilizer
// PURPOSE
//   Upstream conditioner for the game controller's mic_note input.
//   - Takes raw per-frame pitch estimates from the mic pitch detector.
//   - Publishes a note only after CONFIRM_COUNT consecutive identical valid samples.
//   - Falls back to silence when no sample arrives for SILENCE_TIMEOUT cycles.
//   - Keeps scoring from crediting momentary pitch glitches.
// PARAMETERS
//   CONFIRM_COUNT    4             consecutive matching samples needed to commit (>=1)
//   SILENCE_TIMEOUT  24'd5_000_000 idle cycles (50 ms @100 MHz) before forcing silence
//   NOTE_SILENT      7'd0          code published for "no note"
//   NOTE_INVALID     7'h7F         reserved code (song-finish sentinel); never published
// PORTS
//   clk_in        in   1   system clock; one clock domain
//   rst_n_in      in   1   reset, asynchronous and active-low
//   enable_in     in   1   game_on; low = synchronous clear to reset state
//   raw_note_in   in   7   raw detector note code
//   raw_valid_in  in   1   1-cycle strobe, raw_note_in valid
//   stable_note   out  7   committed note, drives game controller mic_note
//   note_change   out  1   1-cycle pulse in the cycle stable_note takes a new value
//   locked        out  1   1 while stable_note != NOTE_SILENT
//   reject_count  out  16  only with NOTE_STAB_STATS_EN; see CONFIGURATION
// BEHAVIOUR
//   Reset (async assert, sync release) and enable_in==0 (synchronous clear):
//   - stable_note=NOTE_SILENT, note_change=0, locked=0
//   - candidate=NOTE_SILENT, match_cnt=0, idle_cnt=0, state=S_SILENT
//   - enable_in clear never pulses note_change.
//   FSM states:
//   - S_SILENT: stable_note==NOTE_SILENT.
//   - S_ACQUIRE: candidate!=stable_note, match_cnt>0.
//   - S_LOCKED: stable_note non-silent, candidate==stable_note.
//   Valid sample, raw_valid_in=1 and raw_note_in!=NOTE_INVALID:
//   - idle_cnt<=0.
//   - raw==candidate: match_cnt<=min(match_cnt+1, CONFIRM_COUNT) (saturates).
//   - Else: candidate<=raw, match_cnt<=1.
//   Commit: when the updated match_cnt reaches CONFIRM_COUNT and candidate!=stable_note:
//   - stable_note updates on the clock edge that ends the cycle after the sample.
//   - Latency is 1 cycle from the strobe; note_change=1 for that one cycle.
//   - A confirmed NOTE_SILENT is a legal commit: LOCKED->SILENT with a pulse.
//   - CONFIRM_COUNT==1: every differing valid sample commits immediately.
//   Invalid sample, raw_valid_in=1 and raw_note_in==NOTE_INVALID:
//   - match_cnt<=0; candidate and idle_cnt unchanged; stable_note held.
//   Timeout:
//   - idle_cnt increments each cycle without raw_valid_in and saturates at SILENCE_TIMEOUT-1.
//   - On reaching SILENCE_TIMEOUT-1: stable_note<=NOTE_SILENT, candidate<=NOTE_SILENT, match_cnt<=0.
//   - note_change pulses only if stable_note was non-silent.
//   - A valid strobe in the same cycle wins: idle_cnt resets, no forced silence.
//   Other rules:
//   - locked is registered and equals (stable_note!=NOTE_SILENT) in the same cycle.
//   - An outstanding acquisition never blocks a timeout.
//   - Reset mid-acquire discards candidate and count.
// CONFIGURATION
//   NOTE_STAB_STATS_EN defined:
//   - reject_count counts invalid samples plus valid samples that break a run (raw!=candidate, match_cnt>0).
//   - Saturates at 16'hFFFF; cleared by reset or enable_in==0.
//   Undefined: reject_count port absent; core behaviour identical.
// TESTING
//   - Reset: rst_n_in=0 mid-acquire -> stable_note=0, locked=0, note_change=0 immediately (async).
//   - Commit: 4 strobes of note 60 -> stable_note=60 exactly 1 cycle after 4th strobe; single note_change pulse; locked=1.
//   - Glitch: 60,60,62,60,60,60 after lock on 55 -> no change until 4th consecutive 60; 62 never published.
//   - Timeout: locked on 60, no strobes for 5_000_000 cycles -> stable_note=0, one pulse. Strobe on the final cycle -> stays 60.
//   - Invalid: 60,60,7F,60,60 -> no commit (run broken); reject_count=1 with NOTE_STAB_STATS_EN.
//   - Enable: enable_in=0 while locked -> next cycle stable_note=0, note_change=0, reject_count=0.

Source files
------------

// File: rtl/note_stabilizer.sv
// Debounces raw mic pitch estimates into a committed note with idle fallback to silence.
// Optional NOTE_STAB_STATS_EN adds a saturating reject_count output.
module note_stabilizer #(
  parameter int unsigned CONFIRM_COUNT   = 4,
  parameter int unsigned SILENCE_TIMEOUT = 5_000_000,
  parameter logic [6:0]  NOTE_SILENT     = 7'd0,
  parameter logic [6:0]  NOTE_INVALID    = 7'h7F
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        enable_in,
  input  logic [6:0]  raw_note_in,
  input  logic        raw_valid_in,
  output logic [6:0]  stable_note,
  output logic        note_change,
  output logic        locked
`ifdef NOTE_STAB_STATS_EN
  ,
  output logic [15:0] reject_count
`endif
);

  localparam int unsigned MW = $clog2(CONFIRM_COUNT + 1);
  localparam int unsigned IW = $clog2(SILENCE_TIMEOUT);
  localparam logic [MW-1:0] MATCH_MAX = MW'(CONFIRM_COUNT);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(SILENCE_TIMEOUT - 1);

  typedef enum logic [1:0] {S_SILENT, S_ACQUIRE, S_LOCKED} state_e;

  state_e        r_state_q, w_state_d;
  logic [6:0]    r_stable_q, w_stable_d;
  logic [6:0]    r_cand_q, w_cand_d;
  logic [MW-1:0] r_match_q, w_match_d;
  logic [IW-1:0] r_idle_q, w_idle_d;
  logic          r_change_q, w_change_d;
  logic          w_good, w_bad;

  assign w_good = raw_valid_in && (raw_note_in != NOTE_INVALID);
  assign w_bad  = raw_valid_in && (raw_note_in == NOTE_INVALID);

  always_comb begin
    w_stable_d = r_stable_q;
    w_cand_d   = r_cand_q;
    w_match_d  = r_match_q;
    w_idle_d   = r_idle_q;
    w_change_d = 1'b0;
    if (!enable_in) begin
      w_stable_d = NOTE_SILENT;
      w_cand_d   = NOTE_SILENT;
      w_match_d  = '0;
      w_idle_d   = '0;
    end else if (w_good) begin
      w_idle_d = '0;
      if (raw_note_in == r_cand_q) begin
        if (r_match_q < MATCH_MAX) w_match_d = r_match_q + 1'b1;
      end else begin
        w_cand_d  = raw_note_in;
        w_match_d = MW'(1);
      end
      // Commit uses the updated count so the note lands on the sampling edge.
      if ((w_match_d == MATCH_MAX) && (w_cand_d != r_stable_q)) begin
        w_stable_d = w_cand_d;
        w_change_d = 1'b1;
      end
    end else if (w_bad) begin
      w_match_d = '0;
    end else if (r_idle_q == IDLE_MAX) begin
      w_stable_d = NOTE_SILENT;
      w_cand_d   = NOTE_SILENT;
      w_match_d  = '0;
      w_change_d = (r_stable_q != NOTE_SILENT);
    end else begin
      w_idle_d = r_idle_q + 1'b1;
    end

    if (w_stable_d == NOTE_SILENT) begin
      w_state_d = S_SILENT;
    end else if ((w_cand_d != w_stable_d) && (w_match_d != '0)) begin
      w_state_d = S_ACQUIRE;
    end else begin
      w_state_d = S_LOCKED;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state_q  <= S_SILENT;
      r_stable_q <= NOTE_SILENT;
      r_cand_q   <= NOTE_SILENT;
      r_match_q  <= '0;
      r_idle_q   <= '0;
      r_change_q <= 1'b0;
    end else begin
      r_state_q  <= w_state_d;
      r_stable_q <= w_stable_d;
      r_cand_q   <= w_cand_d;
      r_match_q  <= w_match_d;
      r_idle_q   <= w_idle_d;
      r_change_q <= w_change_d;
    end
  end

  assign stable_note = r_stable_q;
  assign note_change = r_change_q;
  assign locked      = (r_state_q != S_SILENT);

`ifdef NOTE_STAB_STATS_EN
  logic [15:0] r_rej_q, w_rej_d;
  logic        w_reject;

  // A reject is an invalid sample or a valid one that breaks a run in progress.
  assign w_reject = w_bad || (w_good && (raw_note_in != r_cand_q) && (r_match_q != '0));

  always_comb begin
    w_rej_d = r_rej_q;
    if (!enable_in) begin
      w_rej_d = '0;
    end else if (w_reject && (r_rej_q != 16'hFFFF)) begin
      w_rej_d = r_rej_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_rej_q <= '0;
    else           r_rej_q <= w_rej_d;
  end

  assign reject_count = r_rej_q;
`endif

endmodule
